// File: rtl/btn_pkg.sv
// Shared constants for the push-button front end: default debounce depth and
// the raw level a released button presents for a given polarity.
package btn_pkg;

  localparam int   DEFAULT_STABLE_CNT   = 16;
  localparam bit   DEFAULT_ACTIVE_LOW   = 1'b1;
  localparam logic DEFAULT_RELEASED_RAW = DEFAULT_ACTIVE_LOW ? 1'b1 : 1'b0;

  // Raw idle level; active-low buttons idle high.
  function automatic logic released_raw(input bit active_low);
    return active_low ? 1'b1 : 1'b0;
  endfunction

endpackage

// File: rtl/debounce_chan.sv
// One button channel: two-flop synchroniser, polarity normalisation,
// consecutive-sample debounce and a registered one-cycle press pulse.
module debounce_chan
  import btn_pkg::*;
#(
  parameter int STABLE_CNT = DEFAULT_STABLE_CNT,
  parameter int ACTIVE_LOW = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic lvl,
  output logic press
);

  localparam int            CW      = $clog2(STABLE_CNT);
  localparam logic          REL     = released_raw(ACTIVE_LOW != 0);
  localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CNT - 1);

  logic          sync1;
  logic          sync2;
  logic          norm;
  logic          stable;
  logic          stable_q;
  logic          press_q;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= REL;
      sync2 <= REL;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  assign norm = (ACTIVE_LOW != 0) ? ~sync2 : sync2;

  // Any sample matching the accepted level restarts the count; the counter
  // saturates at the accept point, so it never wraps.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stable <= 1'b0;
      cnt    <= '0;
    end else if (norm == stable) begin
      cnt <= '0;
    end else if (cnt == CNT_MAX) begin
      stable <= norm;
      cnt    <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stable_q <= 1'b0;
      press_q  <= 1'b0;
    end else begin
      stable_q <= stable;
      press_q  <= stable & ~stable_q;
    end
  end

  assign lvl   = stable;
  assign press = press_q;

endmodule

// File: rtl/button_conditioner.sv
// Conditions the run/hold push buttons into clean level and one-cycle press
// outputs; a simultaneous press is resolved in favour of hold.
module button_conditioner
  import btn_pkg::*;
#(
  parameter int STABLE_CNT = DEFAULT_STABLE_CNT,
  parameter int ACTIVE_LOW = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_run_raw,
  input  logic btn_hold_raw,
  output logic run,
  output logic hold,
  output logic run_lvl,
  output logic hold_lvl
);

  logic run_press;
  logic hold_press;

  debounce_chan #(
    .STABLE_CNT (STABLE_CNT),
    .ACTIVE_LOW (ACTIVE_LOW)
  ) u_run (
    .clk   (clk),
    .rst   (rst),
    .raw   (btn_run_raw),
    .lvl   (run_lvl),
    .press (run_press)
  );

  debounce_chan #(
    .STABLE_CNT (STABLE_CNT),
    .ACTIVE_LOW (ACTIVE_LOW)
  ) u_hold (
    .clk   (clk),
    .rst   (rst),
    .raw   (btn_hold_raw),
    .lvl   (hold_lvl),
    .press (hold_press)
  );

  // Hold wins a tie and the losing run press is dropped, not deferred.
  assign hold = hold_press;
  assign run  = run_press & ~hold_press;

endmodule

// File: tb/tb_button_conditioner.sv
// Scoreboard bench for button_conditioner: a run-length reference model
// predicts levels and pulse cycles, a negedge monitor checks the DUT.
module tb_button_conditioner;

  localparam int N = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic btn_run_raw = 1'b1;
  logic btn_hold_raw = 1'b1;
  logic run, hold, run_lvl, hold_lvl;

  button_conditioner #(.STABLE_CNT(N), .ACTIVE_LOW(1)) dut (
    .clk          (clk),
    .rst          (rst),
    .btn_run_raw  (btn_run_raw),
    .btn_hold_raw (btn_hold_raw),
    .run          (run),
    .hold         (hold),
    .run_lvl      (run_lvl),
    .hold_lvl     (hold_lvl)
  );

  always #5 clk = ~clk;

  int total = 0;
  int passed = 0;

  task automatic chk(input string name, input int got, input int exp);
    total++;
    if (got == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d at time %0t", name, got, exp, $time);
  endtask

  typedef struct {
    int cyc;
    bit kind; // 0 = run, 1 = hold
  } ev_t;
  ev_t sbq[$];

  // Reference model: index 0 = run, 1 = hold. Pressed-normalised samples pass
  // through a 2-deep delay; a new level is accepted once the sampled value has
  // been seen N times in a row and differs from the accepted level.
  int ecyc;
  bit h0[2], h1[2], prev_s[2], mst[2], rose[2];
  int runlen[2];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      ecyc = 0;
      for (int c = 0; c < 2; c++) begin
        h0[c] = 0; h1[c] = 0; prev_s[c] = 0; mst[c] = 0; runlen[c] = 0; rose[c] = 0;
      end
      sbq.delete();
    end else begin
      bit p[2];
      p[0] = ~btn_run_raw;
      p[1] = ~btn_hold_raw;
      ecyc++;
      for (int c = 0; c < 2; c++) begin
        bit s;
        s = h1[c];
        h1[c] = h0[c];
        h0[c] = p[c];
        runlen[c] = (s == prev_s[c]) ? runlen[c] + 1 : 1;
        prev_s[c] = s;
        rose[c] = 0;
        if (s != mst[c] && runlen[c] >= N) begin
          mst[c] = s;
          rose[c] = s;
        end
      end
      if (rose[1]) sbq.push_back('{cyc: ecyc + 1, kind: 1'b1});
      else if (rose[0]) sbq.push_back('{cyc: ecyc + 1, kind: 1'b0});
    end
  end

  int run_cnt, hold_cnt, last_run_cyc, last_hold_cyc;

  always @(negedge clk) begin
    if (!rst) begin
      chk("run_lvl", run_lvl, mst[0]);
      chk("hold_lvl", hold_lvl, mst[1]);
      chk("exclusive", int'(run & hold), 0);
      while (sbq.size() > 0 && sbq[0].cyc < ecyc) begin
        chk("missed_pulse_cycle", ecyc, sbq[0].cyc);
        void'(sbq.pop_front());
      end
      if (run | hold) begin
        if (run) begin run_cnt++; last_run_cyc = ecyc; end
        if (hold) begin hold_cnt++; last_hold_cyc = ecyc; end
        if (sbq.size() == 0) begin
          chk("unexpected_pulse_queue", sbq.size(), 1);
        end else begin
          ev_t e;
          e = sbq.pop_front();
          chk("pulse_cycle", ecyc, e.cyc);
          chk("pulse_kind", int'(hold), int'(e.kind));
        end
      end
    end
  end

  task automatic clear_counts();
    run_cnt = 0; hold_cnt = 0; last_run_cyc = -1; last_hold_cyc = -1;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int start;
    int dur[2];
    clear_counts();
    cycles(3);
    chk("rst_run", run, 0);
    chk("rst_hold", hold, 0);
    chk("rst_run_lvl", run_lvl, 0);
    chk("rst_hold_lvl", hold_lvl, 0);

    // Clean press: raw falls before the first sampling edge after reset.
    btn_run_raw = 1'b0;
    rst = 1'b0;
    cycles(12);
    chk("clean_run_cnt", run_cnt, 1);
    chk("clean_run_cyc", last_run_cyc, 7);
    chk("clean_hold_cnt", hold_cnt, 0);
    chk("clean_run_lvl", run_lvl, 1);
    btn_run_raw = 1'b1;
    cycles(10);

    // Bounce on hold, then held low.
    clear_counts();
    for (int i = 0; i < 10; i++) begin
      btn_hold_raw = (i % 2 == 0) ? 1'b0 : 1'b1;
      cycles(2);
    end
    chk("bounce_no_pulse", hold_cnt, 0);
    btn_hold_raw = 1'b0;
    start = ecyc;
    cycles(12);
    chk("bounce_hold_cnt", hold_cnt, 1);
    chk("bounce_hold_delay", last_hold_cyc - start, 7);
    btn_hold_raw = 1'b1;
    cycles(10);

    // Short glitch on run.
    clear_counts();
    btn_run_raw = 1'b0;
    cycles(3);
    btn_run_raw = 1'b1;
    cycles(10);
    chk("glitch_run_cnt", run_cnt, 0);
    chk("glitch_run_lvl", run_lvl, 0);

    // Simultaneous press.
    clear_counts();
    btn_run_raw = 1'b0;
    btn_hold_raw = 1'b0;
    cycles(12);
    chk("simul_hold_cnt", hold_cnt, 1);
    chk("simul_run_cnt", run_cnt, 0);
    chk("simul_run_lvl", run_lvl, 1);
    chk("simul_hold_lvl", hold_lvl, 1);
    btn_run_raw = 1'b1;
    btn_hold_raw = 1'b1;
    cycles(10);

    // Hold-down then re-press.
    clear_counts();
    btn_run_raw = 1'b0;
    cycles(100);
    btn_run_raw = 1'b1;
    cycles(10);
    btn_run_raw = 1'b0;
    cycles(12);
    chk("repress_run_cnt", run_cnt, 2);
    btn_run_raw = 1'b1;
    cycles(10);

    // Async reset while pressed; button kept down through reset.
    btn_run_raw = 1'b0;
    cycles(8);
    chk("pre_reset_run_lvl", run_lvl, 1);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_run_lvl", run_lvl, 0);
    chk("async_rst_hold_lvl", hold_lvl, 0);
    chk("async_rst_run", run, 0);
    chk("async_rst_hold", hold, 0);
    cycles(2);
    clear_counts();
    rst = 1'b0;
    cycles(12);
    chk("post_rst_run_cnt", run_cnt, 1);
    chk("post_rst_run_cyc", last_run_cyc, 7);
    btn_run_raw = 1'b1;
    cycles(10);

    // Random bursty stimulus on both buttons.
    dur[0] = 1;
    dur[1] = 1;
    for (int i = 0; i < 3000; i++) begin
      if (--dur[0] == 0) begin
        btn_run_raw = ~btn_run_raw;
        dur[0] = $urandom_range(1, 10);
      end
      if (--dur[1] == 0) begin
        btn_hold_raw = ~btn_hold_raw;
        dur[1] = $urandom_range(1, 10);
      end
      cycles(1);
    end
    btn_run_raw = 1'b1;
    btn_hold_raw = 1'b1;
    cycles(20);
    chk("final_queue_empty", sbq.size(), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/button_conditioner.md
# button_conditioner

Front-end stage for the LED sweep controller. Takes the two raw, bouncy, asynchronous push-button inputs and produces the clean, single-cycle `run` and `hold` request pulses the controller consumes, plus debounced level outputs. Each button is synchronised, debounced with a consecutive-sample counter and edge-detected. Simultaneous requests are arbitrated so the downstream stage never sees `run` and `hold` together.

## Interface
- `STABLE_CNT`, default 16: consecutive synchronised samples a new button level must hold before it is accepted; legal range ≥2.
- `ACTIVE_LOW`, default 1: 1 means a raw input reads 0 when pressed; 0 means it reads 1 when pressed.
- `clk`  in  1: single clock; all state is on its rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `btn_run_raw`  in  1: raw run button, asynchronous to `clk`.
- `btn_hold_raw`  in  1: raw hold button, asynchronous to `clk`.
- `run`  out  1: one-cycle pulse on an accepted run press.
- `hold`  out  1: one-cycle pulse on an accepted hold press.
- `run_lvl`  out  1: debounced run level, 1 = pressed.
- `hold_lvl`  out  1: debounced hold level, 1 = pressed.

## Operation
- Reset values: all outputs are 0. Synchronisers reset to the released level (`ACTIVE_LOW` ? 1 : 0). Stable levels reset to released. Counters reset to 0.
- Per channel:
  - Two-flop synchroniser, then polarity normalisation to pressed=1.
  - Debounce state is `stable` (1 bit) plus `cnt`, which is $clog2(STABLE_CNT) bits wide and unsigned.
  - Each edge where the synchronised value equals `stable`: `cnt` is set to 0.
  - Each edge where it differs and `cnt` < STABLE_CNT-1: `cnt` increments.
  - Each edge where it differs and `cnt` == STABLE_CNT-1: `stable` takes the synchronised value and `cnt` is set to 0.
  - `cnt` never wraps.
- Press detect: registered `stable & ~stable_q`, where `stable_q` is `stable` delayed by one cycle. Releases produce no pulse.
- Arbitration: if run and hold press detects occur on the same edge, `hold` pulses and that run detect is discarded. No queuing.
- A held button yields exactly one pulse. The next pulse requires an accepted release followed by an accepted press.
- `run_lvl`/`hold_lvl` equal the channel's `stable` directly, with no extra register.
- Reset mid-operation clears all state immediately. A button held through reset is treated as a new press: one pulse after full debounce from reset release.

## Timing
- Latency: raw level first sampled at edge 0 and held steady.
  - Synchronised value differs from edge 1.
  - `stable` flips at edge STABLE_CNT+1, so `*_lvl` rises after that edge.
  - Pulse is high for exactly the cycle after edge STABLE_CNT+2.
- Glitch rejection: any bounce shorter than STABLE_CNT synchronised samples produces no level change and no pulse. A single opposite sample restarts the count from 0.
- Throughput: minimum spacing between two pulses on one channel is 2×STABLE_CNT cycles (release plus press debounce).
- `run` and `hold` are never high in the same cycle.

## Structure
- Package `btn_pkg`: `DEFAULT_STABLE_CNT` (16) and a localparam for the released raw level derived from `ACTIVE_LOW`.
- Sub-module `debounce_chan`, instantiated twice.
  - Contains the synchroniser, polarity normalisation, counter, `stable`, and the registered press pulse.
  - Ports: `clk`, `rst`, `raw`, `lvl`, `press`.
- Top level holds only the arbitration and output assignment. Arbitration is combinational on the two `press` signals, so there is no added latency.

## Test plan
- Clean press, STABLE_CNT=4, ACTIVE_LOW=1: `btn_run_raw` driven 1→0 before edge 0 and held → `run_lvl`=1 after edge 5, `run`=1 only in the cycle after edge 6, `hold`=0 throughout.
- Bounce: `btn_hold_raw` toggles 0/1 every 2 cycles for 20 cycles, then is held low → no `hold` pulse during toggling, exactly one `hold` pulse 6 cycles after the final steady low.
- Glitch: `btn_run_raw` low for 3 cycles then high → `run_lvl` and `run` stay 0.
- Simultaneous press: both raw inputs fall on the same edge → one `hold` pulse, no `run` pulse; `run_lvl` and `hold_lvl` both 1.
- Hold-down and re-press: run held 100 cycles, released 10, pressed again → exactly two `run` pulses total.
- Async reset mid-debounce: `rst` asserted between edges during a count → outputs 0 immediately. Button still pressed at `rst` release → one `run` pulse at edge 6 after release.
